// File: rtl/motorb_act_stream_pkg.sv
// motorB activation stream: shared mode/state encodings and lane slicing helper.
package motorB_act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU     = 2'd0,
    ACT_LEAKY    = 2'd1,
    ACT_CLIP     = 2'd2,
    ACT_RELU_ALT = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_state_e;

  // Low bit index of lane k in a packed beat of w-bit words.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/motorb_act_stream_lane.sv
// Single-lane combinational activation. Sign/zero and clip-compare flags are
// precomputed one stage earlier so this stage is only a mux plus a fixed shift.
module motorB_act_lane
  import motorB_act_pkg::*;
#(
  parameter int             W          = 32,
  parameter int             LEAK_SHIFT = 3,
  parameter logic [W-1:0]   CLIP_VAL   = '0
)(
  input  logic [W-1:0] i_x,
  input  act_mode_e    i_mode,
  input  logic         i_pos,      // x > 0
  input  logic         i_gt_clip,  // x > CLIP_VAL (signed)
  output logic [W-1:0] o_y
);

  logic signed [W-1:0] w_shr;

  // Arithmetic shift rounds toward -inf; most-negative input needs no special case.
  assign w_shr = $signed(i_x) >>> LEAK_SHIFT;

  // Mode select; code 3 aliases plain ReLU.
  always_comb begin
    o_y = '0;
    case (i_mode)
      ACT_LEAKY: o_y = i_pos ? i_x : w_shr;
      ACT_CLIP:  o_y = !i_pos ? '0 : (i_gt_clip ? CLIP_VAL : i_x);
      default:   o_y = i_pos ? i_x : '0;
    endcase
  end

endmodule

// File: rtl/motorb_act_stream.sv
// motorB activation stream top: ap_start/ap_done frame controller around a
// two-stage valid/ready pipeline applying ReLU / leaky / clipped-ReLU per lane.
module motorb_act_stream
  import motorB_act_pkg::*;
#(
  parameter int           W          = 32,
  parameter int           I          = 8,
  parameter int           N_CH       = 4,
  parameter int           FRAME_LEN  = 16,
  parameter int           LEAK_SHIFT = 3,
  parameter logic [W-1:0] CLIP_VAL   = {{(W-3){1'b0}}, 3'd6} << (W-I)
)(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic [1:0]        mode,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH*W-1:0] out_data
);

  localparam int            CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

  act_state_e        r_state, w_state_nxt;
  act_mode_e         r_mode_q;
  logic [CW-1:0]     r_in_cnt, r_out_cnt;
  logic [1:0]        r_vld_pipe;            // [0] = S1, [1] = S2 (out_valid)
  logic [N_CH*W-1:0] r_s1_data, r_out_data;
  logic [N_CH-1:0]   r_s1_pos, r_s1_gt;
  logic [N_CH-1:0]   w_pos, w_gt;
  logic [N_CH*W-1:0] w_y;
  logic              w_s1_adv, w_s2_adv, w_in_fire, w_out_fire, w_start;

  // A stage may load when its successor is empty or draining this cycle.
  assign w_s2_adv   = !r_vld_pipe[1] || out_ready;
  assign w_s1_adv   = !r_vld_pipe[0] || w_s2_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_vld_pipe[1] && out_ready;
  assign w_start    = (r_state == IDLE) && ap_start;
  assign out_valid  = r_vld_pipe[1];
  assign out_data   = r_out_data;

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state: frame ends once every accepted beat has left the pipe.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ap_start)          w_state_nxt = RUN;
      RUN:     if (r_in_cnt == FL)    w_state_nxt = DRAIN;
      DRAIN:   if (r_out_cnt == FL)   w_state_nxt = DONE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Status outputs and input acceptance.
  always_comb begin
    ap_idle  = (r_state == IDLE);
    ap_done  = (r_state == DONE);
    in_ready = (r_state == RUN) && (r_in_cnt < FL) && w_s1_adv;
  end

  // Mode latch and beat counters; counters saturate at FRAME_LEN.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_mode_q  <= ACT_RELU;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start) begin
      r_mode_q  <= act_mode_e'(mode);
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_fire  && r_in_cnt  != FL) r_in_cnt  <= r_in_cnt  + CW'(1);
      if (w_out_fire && r_out_cnt != FL) r_out_cnt <= r_out_cnt + CW'(1);
    end
  end

  // Pipeline: S1 captures raw beat + flags, S2 captures the activated result.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_s1_pos   <= '0;
      r_s1_gt    <= '0;
      r_out_data <= '0;
    end else begin
      if (w_s1_adv) begin
        r_vld_pipe[0] <= w_in_fire;
        if (w_in_fire) begin
          r_s1_data <= in_data;
          r_s1_pos  <= w_pos;
          r_s1_gt   <= w_gt;
        end
      end
      if (w_s2_adv) begin
        r_vld_pipe[1] <= r_vld_pipe[0];
        if (r_vld_pipe[0]) r_out_data <= w_y;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [W-1:0] w_x;
    assign w_x      = in_data[lane_lo(k, W) +: W];
    assign w_pos[k] = !w_x[W-1] && (|w_x);
    assign w_gt[k]  = $signed(w_x) > $signed(CLIP_VAL);

    motorB_act_lane #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CLIP_VAL   (CLIP_VAL)
    ) u_lane (
      .i_x       (r_s1_data[lane_lo(k, W) +: W]),
      .i_mode    (r_mode_q),
      .i_pos     (r_s1_pos[k]),
      .i_gt_clip (r_s1_gt[k]),
      .o_y       (w_y[lane_lo(k, W) +: W])
    );
  end

endmodule

// File: tb/tb_motorb_act_stream.sv
// Directed bench for motorb_act_stream: per-mode vectors, framing, backpressure,
// mode latching and mid-frame reset.
module tb_motorb_act_stream;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int FL = 16;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n, ap_start, ap_idle, ap_done;
  logic [1:0]     mode;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0] in_data, out_data;

  int n_chk = 0, n_fail = 0;

  logic [N*W-1:0] src[$], exp_q[$], got[$];
  int   n_done, n_done_early, n_stall_bad, n_extra_rdy, lat;
  logic timeout, idle_end;

  always #5 ap_clk = ~ap_clk;

  motorb_act_stream dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .mode(mode),
    .ap_idle(ap_idle), .ap_done(ap_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [W-1:0] act_ref(input logic [1:0] m, input logic [W-1:0] x);
    logic signed [W-1:0] s;
    s = x;
    if (m == 2'd1) return (s > 0) ? x : W'(s >>> 3);
    if (m == 2'd2) return (s <= 0) ? '0 : ((s > 32'sh0600_0000) ? 32'h0600_0000 : x);
    return (s > 0) ? x : '0;
  endfunction

  function automatic logic [N*W-1:0] beat_ref(input logic [1:0] m, input logic [N*W-1:0] b);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = act_ref(m, b[k*W +: W]);
    return r;
  endfunction

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic start_frame(input logic [1:0] m);
    ap_start = 1'b1; mode = m; in_valid = 1'b0;
    tick();
    ap_start = 1'b0;
  endtask

  // Drives src as one frame, records outputs and protocol observations.
  task automatic stream(input int rdy_pct, input int mid_cyc, input logic [1:0] mid_mode);
    int sent, post, first_in, first_ov;
    logic prev_stall;
    logic [N*W-1:0] prev;
    sent = 0; post = 0; first_in = -1; first_ov = -1; prev_stall = 0; prev = '0;
    got.delete(); n_done = 0; n_done_early = 0; n_stall_bad = 0; n_extra_rdy = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = (sent < src.size());
      in_data   = in_valid ? src[sent] : '0;
      out_ready = ($urandom_range(99) < rdy_pct);
      ap_start  = (c == mid_cyc);
      if (c == mid_cyc) mode = mid_mode;
      #1;
      if (prev_stall && out_data !== prev) n_stall_bad++;
      if (sent >= FL && in_ready) n_extra_rdy++;
      if (ap_done) begin n_done++; if (got.size() < FL) n_done_early++; end
      if (in_valid && in_ready) begin if (first_in < 0) first_in = c; sent++; end
      if (out_valid && first_ov < 0) first_ov = c;
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev = out_data;
      if (got.size() >= FL) post++;
      @(posedge ap_clk); #1;
      if (post >= 4) break;
    end
    in_valid = 0; ap_start = 0; out_ready = 1;
    timeout  = (post < 4);
    idle_end = ap_idle;
    lat      = first_ov - first_in;
  endtask

  task automatic test_reset();
    ap_rst_n = 0; ap_start = 0; mode = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (3) tick();
    ap_rst_n = 1; #1;
    n_chk++; if (ap_idle !== 1'b1)   begin n_fail++; $display("FAIL reset_idle: got %b exp 1", ap_idle); end
    n_chk++; if (ap_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b exp 0", ap_done); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_odata: got %h exp 0", out_data); end
    n_chk++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_irdy: got %b exp 0", in_ready); end
    tick();
  endtask

  // Frame of identical beats with out_ready=1; checks results, latency, framing.
  task automatic run_vec(input string nm, input logic [1:0] m,
                         input logic [N*W-1:0] vin, input logic [N*W-1:0] vexp);
    src.delete();
    for (int i = 0; i < FL; i++) src.push_back(vin);
    start_frame(m);
    stream(100, -1, 2'd0);
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %b exp 0", nm, timeout); end
    n_chk++; if (got.size() != FL) begin n_fail++; $display("FAIL %s_count: got %0d exp %0d", nm, got.size(), FL); end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++; if (got[i] !== vexp) begin n_fail++; $display("FAIL %s_data[%0d]: got %h exp %h", nm, i, got[i], vexp); end
    end
    n_chk++; if (lat != 2)      begin n_fail++; $display("FAIL %s_latency: got %0d exp 2", nm, lat); end
    n_chk++; if (n_done != 1)   begin n_fail++; $display("FAIL %s_done: got %0d exp 1", nm, n_done); end
    n_chk++; if (idle_end !== 1'b1) begin n_fail++; $display("FAIL %s_idle: got %b exp 1", nm, idle_end); end
  endtask

  task automatic test_relu();
    run_vec("relu", 2'd0, {32'h7FFF_FFFF, 32'h0000_0000, 32'hFF00_0000, 32'h0100_0000},
                          {32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000});
    run_vec("relu3", 2'd3, {32'h7FFF_FFFF, 32'h0000_0000, 32'hFF00_0000, 32'h0100_0000},
                           {32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000});
  endtask

  task automatic test_leaky();
    run_vec("leaky", 2'd1, {32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFF00_0000},
                           {32'h0000_0010, 32'hFFFF_FFFF, 32'hF000_0000, 32'hFFE0_0000});
  endtask

  task automatic test_clip();
    run_vec("clip", 2'd2, {32'h8000_0001, 32'h05FF_FFFF, 32'h0600_0000, 32'h0700_0000},
                          {32'h0000_0000, 32'h05FF_FFFF, 32'h0600_0000, 32'h0600_0000});
  endtask

  task automatic test_backpressure();
    src.delete(); exp_q.delete();
    for (int i = 0; i < FL; i++) begin
      logic [N*W-1:0] b;
      for (int k = 0; k < N; k++) b[k*W +: W] = W'(i * 32'h0123_4567 + k * 32'h3C00_0000 + 32'h0480_0000);
      src.push_back(b); exp_q.push_back(beat_ref(2'd2, b));
    end
    start_frame(2'd2);
    stream(50, -1, 2'd0);
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b exp 0", timeout); end
    n_chk++; if (got.size() != FL) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", got.size(), FL); end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
    n_chk++; if (n_stall_bad != 0)  begin n_fail++; $display("FAIL bp_stable: got %0d changes exp 0", n_stall_bad); end
    n_chk++; if (n_extra_rdy != 0)  begin n_fail++; $display("FAIL bp_irdy_after: got %0d exp 0", n_extra_rdy); end
    n_chk++; if (n_done != 1)       begin n_fail++; $display("FAIL bp_done: got %0d exp 1", n_done); end
    n_chk++; if (n_done_early != 0) begin n_fail++; $display("FAIL bp_done_early: got %0d exp 0", n_done_early); end
    n_chk++; if (idle_end !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b exp 1", idle_end); end
  endtask

  task automatic test_mode_latch();
    src.delete(); exp_q.delete();
    for (int i = 0; i < FL; i++) begin
      logic [N*W-1:0] b;
      for (int k = 0; k < N; k++) b[k*W +: W] = W'(32'hF000_0000 - i * 32'h0010_0008 + k * 32'h0800_0000);
      src.push_back(b); exp_q.push_back(beat_ref(2'd1, b));
    end
    start_frame(2'd1);
    stream(70, 3, 2'd0);
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ml_timeout: got %b exp 0", timeout); end
    n_chk++; if (got.size() != FL) begin n_fail++; $display("FAIL ml_count: got %0d exp %0d", got.size(), FL); end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ml_data[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
    n_chk++; if (n_done != 1)       begin n_fail++; $display("FAIL ml_done: got %0d exp 1", n_done); end
    n_chk++; if (idle_end !== 1'b1) begin n_fail++; $display("FAIL ml_idle: got %b exp 1", idle_end); end
    tick(); #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ml_no_restart: got %b exp 0", in_ready); end
  endtask

  task automatic test_reset_mid();
    start_frame(2'd1);
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = {4{W'(32'h8000_0000 + i)}};
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_irdy[%0d]: got %b exp 1", i, in_ready); end
      tick();
    end
    in_valid = 0; ap_rst_n = 0;
    tick();
    ap_rst_n = 1; #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ovalid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== '0)    begin n_fail++; $display("FAIL rm_odata: got %h exp 0", out_data); end
    n_chk++; if (ap_idle !== 1'b1)   begin n_fail++; $display("FAIL rm_idle: got %b exp 1", ap_idle); end
    begin
      int dseen;
      dseen = 0;
      for (int c = 0; c < 4; c++) begin if (ap_done || out_valid) dseen++; tick(); end
      n_chk++; if (dseen != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d exp 0", dseen); end
    end
    // A fresh frame must complete normally after the abort.
    run_vec("rm_fresh", 2'd0, {32'h0000_0001, 32'h8000_0000, 32'h0123_4567, 32'hFFFF_FFFF},
                              {32'h0000_0001, 32'h0000_0000, 32'h0123_4567, 32'h0000_0000});
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky();
    test_clip();
    test_backpressure();
    test_mode_latch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/motorb_act_stream.md
Name: motorB_act_stream

Overview:
- Parametrised, pipelined, multi-channel activation unit for the motorB fixed-point inference datapath.
- Sits between a dense/conv layer output stream and the next layer input.
- Applies ReLU, leaky-ReLU or clipped-ReLU lane-wise to N_CH signed fixed-point words per beat, with valid/ready streaming.
- Wrapped in an ap_start/ap_done/ap_idle frame controller that counts FRAME_LEN beats per invocation.

Parameters:
- W, 32, total bits per fixed-point word (signed, two's complement).
- I, 8, integer bits incl. sign; fractional bits F = W-I.
- N_CH, 4, lanes per beat.
- FRAME_LEN, 16, beats per ap_start invocation (>=1).
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT.
- CLIP_VAL, 6<<(W-I), clipped-ReLU ceiling in raw LSB units (>0).

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset, synchronous, active-low
- ap_start  in  1  begin frame (sampled in IDLE)
- mode  in  2  0=ReLU, 1=leaky, 2=clipped, 3=ReLU; latched on accepted ap_start
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse at frame end
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_data  in  N_CH*W  lane k at bits [k*W +: W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  N_CH*W  activated lanes, same packing and format as input

Behaviour:
- Reset (ap_rst_n=0 at edge): state=IDLE, both pipe valids=0, out_data=0, out_valid=0, ap_done=0, counters=0, mode_q=0. ap_idle=1 the cycle after reset. Reset mid-frame aborts: pipeline flushed, no ap_done, partial beats discarded.
- FSM (registered): IDLE -> RUN on ap_start=1 (latch mode, clear in_cnt/out_cnt). RUN -> DRAIN when in_cnt reaches FRAME_LEN. DRAIN -> DONE when out_cnt reaches FRAME_LEN. DONE -> IDLE unconditionally after one cycle; ap_done=1 only in DONE. ap_start outside IDLE is ignored. ap_start held high in DONE starts the next frame only once back in IDLE.
- in_ready = (state==RUN) && (in_cnt<FRAME_LEN) && stage-1 can advance. No input accepted in IDLE/DRAIN/DONE.
- Pipeline, 2 register stages:
  - S1 registers input data plus per-lane sign/zero and x>CLIP_VAL flags.
  - S2 registers the selected result into out_data/out_valid.
  - Latency from accepted beat to out_valid: 2 cycles. Throughput: 1 beat/cycle with out_ready=1.
- Backpressure: stage n advances when its successor is empty or being drained that cycle. out_data/out_valid are held stable while out_valid && !out_ready. No beat is lost or duplicated.
- in_cnt increments on input handshake; out_cnt increments on output handshake. Both are $clog2(FRAME_LEN+1) bits and saturate at FRAME_LEN.
- Lane arithmetic (x signed W bits, result signed W bits, never overflows):
  - ReLU: x>0 ? x : 0.
  - Leaky: x>0 ? x : (x >>> LEAK_SHIFT), arithmetic shift, rounding toward -inf.
  - Clipped: x<=0 ? 0 : (x>CLIP_VAL ? CLIP_VAL : x).
  - x==0 yields 0 in all modes. Most-negative input handled by the shift with no special case.
- mode changes during RUN/DRAIN have no effect; mode_q is used throughout the frame.

Decomposition:
- Package motorB_act_pkg: mode encodings (ACT_RELU, ACT_LEAKY, ACT_CLIP), FSM state enum (IDLE, RUN, DRAIN, DONE), lane slice helper.
- Sub-module motorB_act_lane: combinational single-lane activation (x, mode, flags -> y), instantiated N_CH times via generate.
- Top module: FSM, counters, pipeline valids.

Test Plan:
- ReLU, defaults: lanes {0x0100_0000, 0xFF00_0000, 0x0000_0000, 0x7FFF_FFFF} -> out {0x0100_0000, 0, 0, 0x7FFF_FFFF}, out_valid 2 cycles after handshake.
- Leaky: lanes {0xFF00_0000, 0x8000_0000, 0xFFFF_FFFF, 0x0000_0010} -> {0xFFE0_0000, 0xF000_0000, 0xFFFF_FFFF, 0x0000_0010}.
- Clipped: lanes {0x0700_0000, 0x0600_0000, 0x05FF_FFFF, 0x8000_0001} -> {0x0600_0000, 0x0600_0000, 0x05FF_FFFF, 0}.
- Frame and backpressure, FRAME_LEN=16, random out_ready ~50%: exactly 16 output beats in order with data stable while stalled. in_ready drops after the 16th accept. A single ap_done pulse follows the 16th output handshake, then ap_idle=1.
- Mode latch and ignored start: start with mode=1, change mode to 0 and pulse ap_start mid-RUN -> all beats leaky, no restart, one ap_done.
- Reset mid-frame: assert ap_rst_n=0 for one cycle after 5 beats -> next cycle out_valid=0, out_data=0, ap_idle=1, no ap_done. A fresh frame then completes normally.
